// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Owns the program counter, issues one instruction
//   memory request at a time and holds the returned word for the IF/ID
//   register until downstream consumes it (pc_write) or a branch redirect
//   squashes it.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   FETCH | request pc, waiting for imem_ready
//   WAIT  | request accepted, waiting for imem_rvalid
//   HOLD  | valid instruction held; next request overlaps consumption
//   DROP  | redirected while a response was in flight; discard it
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   pc_write          1 = held instruction consumed this edge, 0 = stall
//   redirect          branch/jump taken, redirect_pc is the new target
//   imem_req/addr     request channel, accepted on imem_req & imem_ready
//   imem_rvalid/rdata response channel, one pulse per accepted request
//   IF_instruction    held instruction, NOP_INSTR when not valid
//   IF_pcplus4        address of held instruction + 4
//   IF_valid          IF_instruction holds a real fetched instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hFC00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_instruction,
  output logic [31:0] IF_pcplus4,
  output logic        IF_valid
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  logic [31:0] target_pc;
  logic        accept;
  logic        unused_target_lsbs;

  // Targets are word aligned; low bits of redirect_pc carry no meaning here.
  assign target_pc          = {redirect_pc[31:2], 2'b00};
  assign unused_target_lsbs = ^redirect_pc[1:0];

  // Request is combinational on pc_write/redirect so a HOLD-state fetch can
  // issue in the same cycle the held instruction is consumed.
  always_comb begin
    imem_req = 1'b0;
    if (!redirect) begin
      case (state_q)
        ST_FETCH: imem_req = 1'b1;
        ST_HOLD:  imem_req = pc_write;
        default:  imem_req = 1'b0;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign accept    = imem_req & imem_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;

    if (redirect) begin
      pc_d    = target_pc;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      // A request still in flight must be drained before a new one issues.
      if ((state_q == ST_WAIT || state_q == ST_DROP) && !imem_rvalid) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (accept) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            instr_d   = imem_rdata;
            pcplus4_d = req_pc_q + 32'd4;
            valid_d   = 1'b1;
            state_d   = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (pc_write) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if (accept) begin
              req_pc_d = pc_q;
              pc_d     = pc_q + 32'd4;
              state_d  = ST_WAIT;
            end else begin
              state_d  = ST_FETCH;
            end
          end
        end
        ST_DROP: begin
          if (imem_rvalid) begin
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      req_pc_q  <= 32'd0;
      instr_q   <= NOP_INSTR;
      pcplus4_q <= 32'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign IF_instruction = instr_q;
  assign IF_pcplus4     = pcplus4_q;
  assign IF_valid       = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'hFC00_0000;

  logic        clk;
  logic        reset;
  logic        pc_write;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_instruction;
  logic [31:0] IF_pcplus4;
  logic        IF_valid;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } exp_t;

  exp_t sb[$];

  int          n_assert = 0;
  int          n_fail   = 0;
  logic        prev_valid = 1'b0;
  int          mem_lat = 1;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_write       (pc_write),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .IF_instruction (IF_instruction),
    .IF_pcplus4     (IF_pcplus4),
    .IF_valid       (IF_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_1234;
  endfunction

  // Memory model: response mem_lat cycles after acceptance; the expected
  // IF-side result is queued at acceptance time.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend        <= 1'b0;
      cnt         <= 0;
      paddr       <= 32'd0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'd0;
    end else begin
      imem_rvalid <= 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= data_of(paddr);
          pend        <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (imem_req && imem_ready) begin
        sb.push_back('{instr: data_of(imem_addr), pcp4: imem_addr + 32'd4});
        if (mem_lat == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= data_of(imem_addr);
        end else begin
          pend  <= 1'b1;
          cnt   <= mem_lat - 1;
          paddr <= imem_addr;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample 1 time unit after the rising edge and check any
  // newly presented instruction against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (IF_valid === 1'b1 && prev_valid === 1'b0) begin
      chk("sb_entry_present", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_instr", IF_instruction, e.instr);
        chk("sb_pcplus4", IF_pcplus4, e.pcp4);
      end
    end
    prev_valid = IF_valid;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    pc_write    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    imem_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, IF_valid}, 32'd0);
    chk("rst_instr", IF_instruction, NOP);
    chk("rst_pcplus4", IF_pcplus4, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    reset = 1'b1;
    settle();
    chk("first_req", {31'd0, imem_req}, 32'd1);

    // Reset sweep, 1-cycle memory, continuous consumption
    for (int k = 0; k < 3; k++) begin
      chk("sweep_req", {31'd0, imem_req}, 32'd1);
      chk("sweep_addr", imem_addr, RST_PC + 32'(4 * k));
      step();
      chk("sweep_wait_valid", {31'd0, IF_valid}, 32'd0);
      chk("sweep_wait_req", {31'd0, imem_req}, 32'd0);
      step();
      chk("sweep_hold_valid", {31'd0, IF_valid}, 32'd1);
      chk("sweep_pcplus4", IF_pcplus4, RST_PC + 32'(4 * k + 4));
    end

    // Stall three cycles in HOLD
    pc_write = 1'b0;
    settle();
    for (int k = 0; k < 3; k++) begin
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_valid", {31'd0, IF_valid}, 32'd1);
      chk("stall_instr", IF_instruction, data_of(32'h108));
      chk("stall_pcplus4", IF_pcplus4, 32'h10C);
      step();
    end
    pc_write = 1'b1;
    settle();
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h10C);
    step();
    step();
    chk("resume_pcplus4", IF_pcplus4, 32'h110);

    // Redirect in HOLD
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2003;
    settle();
    chk("redir_hold_req_forced", {31'd0, imem_req}, 32'd0);
    step();
    redirect = 1'b0;
    settle();
    chk("redir_hold_valid", {31'd0, IF_valid}, 32'd0);
    chk("redir_hold_instr", IF_instruction, NOP);
    chk("redir_hold_pcplus4", IF_pcplus4, 32'h110);
    chk("redir_hold_req", {31'd0, imem_req}, 32'd1);
    chk("redir_hold_addr", imem_addr, 32'h2000);
    step();
    step();
    chk("redir_hold_new_pcplus4", IF_pcplus4, 32'h2004);

    // Redirect in WAIT, response arrives two cycles later
    mem_lat = 3;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3000;
    sb.delete();
    step();
    redirect = 1'b0;
    settle();
    chk("drop_req", {31'd0, imem_req}, 32'd0);
    chk("drop_addr", imem_addr, 32'h3000);
    step();
    chk("drop_rvalid_seen", {31'd0, imem_rvalid}, 32'd1);
    chk("drop_valid", {31'd0, IF_valid}, 32'd0);
    mem_lat = 1;
    step();
    chk("drop_discard_valid", {31'd0, IF_valid}, 32'd0);
    chk("drop_then_req", {31'd0, imem_req}, 32'd1);
    chk("drop_then_addr", imem_addr, 32'h3000);
    step();
    step();
    chk("drop_new_pcplus4", IF_pcplus4, 32'h3004);

    // Redirect coincident with response in WAIT
    step();
    chk("coinc_rvalid", {31'd0, imem_rvalid}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_4000;
    sb.delete();
    settle();
    chk("coinc_req_forced", {31'd0, imem_req}, 32'd0);
    step();
    redirect = 1'b0;
    settle();
    chk("coinc_valid", {31'd0, IF_valid}, 32'd0);
    chk("coinc_instr", IF_instruction, NOP);
    chk("coinc_req", {31'd0, imem_req}, 32'd1);
    chk("coinc_addr", imem_addr, 32'h4000);
    step();
    step();
    chk("coinc_new_pcplus4", IF_pcplus4, 32'h4004);

    // Wrap and backpressure
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    imem_ready  = 1'b0;
    step();
    redirect = 1'b0;
    settle();
    for (int k = 0; k < 4; k++) begin
      chk("bp_req", {31'd0, imem_req}, 32'd1);
      chk("bp_addr", imem_addr, 32'hFFFF_FFFC);
      step();
      settle();
    end
    imem_ready = 1'b1;
    settle();
    chk("bp_release_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    step();
    chk("wrap_valid", {31'd0, IF_valid}, 32'd1);
    chk("wrap_pcplus4", IF_pcplus4, 32'h0000_0000);
    chk("wrap_next_req", {31'd0, imem_req}, 32'd1);
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);

    // Reset asserted with a request outstanding
    mem_lat = 3;
    step();
    reset = 1'b0;
    settle();
    sb.delete();
    prev_valid = 1'b0;
    chk("midrst_valid", {31'd0, IF_valid}, 32'd0);
    chk("midrst_instr", IF_instruction, NOP);
    chk("midrst_pcplus4", IF_pcplus4, 32'd0);
    chk("midrst_addr", imem_addr, RST_PC);
    step();
    reset   = 1'b1;
    mem_lat = 1;
    settle();
    chk("postrst_req", {31'd0, imem_req}, 32'd1);
    chk("postrst_addr", imem_addr, RST_PC);
    step();
    step();
    chk("postrst_pcplus4", IF_pcplus4, RST_PC + 32'd4);

    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch stage.
- Owns the program counter and runs a single-outstanding request/response handshake to instruction memory.
- Drives the IF-side inputs of the IF/ID pipeline register (instruction and PC+4).
- Obeys the same stall (`pc_write`) and branch-redirect controls the hazard/branch logic sends to IF/ID, and presents the NOP bubble `0xFC000000` whenever no valid instruction is held.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: address of the first fetch after reset.
- `NOP_INSTR`, default `32'hFC00_0000`: bubble encoding driven on `IF_instruction` when not valid.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; asserted (0) clears all state immediately.
- `pc_write` in 1: 1 = downstream consumes the held instruction this edge; 0 = stall. Same signal as `IFID_write`.
- `redirect` in 1: branch/jump taken; asserted in the same cycle as `IFID_flush`.
- `redirect_pc` in 32: target address. Bits [1:0] ignored, treated as 00.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: request word address, bits [1:0] always 00.
- `imem_ready` in 1: memory accepts the request this edge when `imem_req & imem_ready`.
- `imem_rvalid` in 1: read data valid, exactly one pulse per accepted request.
- `imem_rdata` in 32: instruction word.
- `IF_instruction` out 32: held instruction, or `NOP_INSTR` when not valid.
- `IF_pcplus4` out 32: address of held instruction + 4.
- `IF_valid` out 1: `IF_instruction` holds a real fetched instruction.

## Operation

State registers:
- `pc`: next address to request.
- `req_pc`: address of the outstanding request.
- FSM with 4 states: FETCH, WAIT, HOLD, DROP.

Reset values:
- State = FETCH, `pc` = `RESET_PC`, `req_pc` = 0.
- `IF_instruction` = `NOP_INSTR`, `IF_pcplus4` = 0, `IF_valid` = 0.

Outputs per state (`imem_req` is forced 0 whenever `redirect` = 1):
- `imem_addr` = `pc` in every state.
- FETCH: `imem_req` = 1. On accept, set `req_pc` <= `pc`, `pc` <= `pc`+4, and move to WAIT.
- WAIT: `imem_req` = 0. On `imem_rvalid`, set `IF_instruction` <= `imem_rdata`, `IF_pcplus4` <= `req_pc`+4, `IF_valid` <= 1, and move to HOLD.
- HOLD: `imem_req` = `pc_write`.
  - `pc_write` = 0: hold all outputs and stay in HOLD.
  - `pc_write` = 1: set `IF_valid` <= 0 and `IF_instruction` <= `NOP_INSTR`. Then:
    - if accepted the same edge, update `req_pc`/`pc` as in FETCH and go to WAIT;
    - otherwise go to FETCH.
- DROP: `imem_req` = 0. On `imem_rvalid`, discard the data and go to FETCH.

Redirect (highest priority, any state, overrides `pc_write`):
- `pc` <= {`redirect_pc`[31:2], 2'b00}.
- `IF_valid` <= 0 and `IF_instruction` <= `NOP_INSTR`. `IF_pcplus4` is unchanged.
- Next state:
  - WAIT with no `imem_rvalid` this cycle: go to DROP (the in-flight response is stale).
  - WAIT with `imem_rvalid` this cycle: discard the data and go to FETCH.
  - DROP with no `imem_rvalid`: stay in DROP, with `pc` updated to the new target.
  - DROP with `imem_rvalid`: go to FETCH.
  - FETCH or HOLD: go to FETCH.

Arithmetic and invariants:
- All address arithmetic is 32-bit modulo 2^32: `0xFFFF_FFFC` + 4 = `0x0000_0000`.
- At most one request is outstanding at any time.
- `imem_rvalid` outside WAIT/DROP is a protocol error and is ignored.

## Timing

- Request accepted at edge N.
  - Earliest `imem_rvalid` is in cycle N+1; same-cycle response is not permitted.
  - `IF_valid` rises at edge N+1 when the response arrives then, i.e. visible in cycle N+2.
- Steady-state throughput with a 1-cycle memory and `pc_write` = 1: one instruction every 2 cycles, because the HOLD-state request overlaps consumption.
- First request after `reset` deassertion: `imem_req` = 1 with `imem_addr` = `RESET_PC` in the first cycle.
- Reset asserted mid-transaction: all state clears asynchronously. The bench does not return a response for the aborted request.
- `imem_req`/`imem_addr` remain stable until accepted, except when `redirect` changes them.

## Test plan

- Reset sweep, `RESET_PC` = `0x100`, 1-cycle memory, `pc_write` = 1:
  - `imem_addr` runs `0x100`, `0x104`, `0x108`;
  - `IF_pcplus4` runs `0x104`, `0x108`, …;
  - `IF_valid` pulses every 2 cycles.
- Stall: hold `pc_write` = 0 for 3 cycles while in HOLD.
  - `IF_instruction`, `IF_pcplus4` and `IF_valid` = 1 stay unchanged.
  - No `imem_req`.
  - Fetch resumes on release.
- Redirect in HOLD to `redirect_pc` = `0x2003`:
  - next edge `IF_valid` = 0 and `IF_instruction` = `0xFC000000`;
  - next request address = `0x2000`.
- Redirect in WAIT with response 2 cycles later:
  - FSM goes to DROP, the response data is discarded (`IF_valid` stays 0);
  - next request address = target.
- Redirect coincident with `imem_rvalid` in WAIT:
  - data discarded, FSM goes to FETCH, target is requested the next cycle.
- Wrap and backpressure: `pc` = `0xFFFFFFFC`, `imem_ready` held low 4 cycles.
  - `imem_req` and `imem_addr` stay stable throughout;
  - after the response, `IF_pcplus4` = `0x00000000`;
  - next request address = `0x0`.
